// File: rtl/game_pkg.sv
// Shared definitions for the game-over overlay sequencer: FSM state type,
// Avalon-MM register word addresses and a counter sizing helper.
package game_pkg;

    // Sequencer states; the encoding is software visible through the status register.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLASH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [1:0] ADDR_STATUS  = 2'd0;
    localparam logic [1:0] ADDR_FLASH   = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_ACK     = 2'd3;

    // Bits needed to hold every value 0..max_val (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/frame_tick_counter.sv
// Loadable down-counter advanced by a tick enable. It stops at zero and
// flags it, so the owner decides what a tick at zero means.
module frame_tick_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             tick_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Load has priority over counting; counting saturates at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (tick_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/game_over_sequencer.sv
// Game-over overlay sequencer: on a rising lose flag it flashes the overlay,
// holds it solid, then waits in DONE for a CPU acknowledge over Avalon-MM.
// Optional interrupt support is built when GAME_OVER_IRQ_EN is defined.
module game_over_sequencer
    import game_pkg::*;
#(
    parameter int unsigned FLASH_COUNT     = 3,
    parameter int unsigned TICKS_PER_PHASE = 15,
    parameter int unsigned HOLD_TICKS      = 60
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        lose_in,
    input  logic        frame_tick,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        overlay_en,
    output logic        freeze_game
`ifdef GAME_OVER_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int unsigned PHASE_W = cnt_width(TICKS_PER_PHASE - 1);
    localparam int unsigned HOLD_W  = cnt_width(HOLD_TICKS - 1);
    localparam int unsigned FLASH_W = cnt_width(2 * FLASH_COUNT);

    localparam logic [PHASE_W-1:0] PHASE_RELOAD = PHASE_W'(TICKS_PER_PHASE - 1);
    localparam logic [HOLD_W-1:0]  HOLD_RELOAD  = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [FLASH_W-1:0] FLASH_INIT   = FLASH_W'(2 * FLASH_COUNT);

    state_e             state_q, state_d;
    logic [FLASH_W-1:0] flash_q, flash_d;
    logic               overlay_q, overlay_d;
    logic               done_q, done_d;

    logic               lose_q;
    logic               primed_q;
    logic               lose_rise;

    logic               wr_en;
    logic               ack;

    logic               phase_load, phase_tick, phase_zero;
    logic [PHASE_W-1:0] phase_load_val;
    logic               hold_load, hold_tick, hold_zero;
    logic [HOLD_W-1:0]  hold_load_val;

    logic               unused_wdata;

    assign unused_wdata = ^writedata[31:1];

    assign wr_en = chipselect & ~write_n;
    assign ack   = wr_en && (address == ADDR_ACK) && writedata[0];

    // The first sample after reset only primes the edge flop, so a lose flag
    // already high at reset release is not mistaken for a new loss.
    assign lose_rise = primed_q & lose_in & ~lose_q;

    // Lose flag edge-detect history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lose_q   <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            lose_q   <= lose_in;
            primed_q <= 1'b1;
        end
    end

    frame_tick_counter #(
        .WIDTH (PHASE_W)
    ) u_phase_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (phase_load),
        .load_val_i (phase_load_val),
        .tick_i     (phase_tick),
        .zero_o     (phase_zero)
    );

    frame_tick_counter #(
        .WIDTH (HOLD_W)
    ) u_hold_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (hold_load),
        .load_val_i (hold_load_val),
        .tick_i     (hold_tick),
        .zero_o     (hold_zero)
    );

    // Next-state logic; an acknowledge overrides everything, including a same-cycle lose edge.
    always_comb begin
        state_d        = state_q;
        flash_d        = flash_q;
        overlay_d      = overlay_q;
        done_d         = done_q;
        phase_load     = 1'b0;
        phase_load_val = '0;
        phase_tick     = 1'b0;
        hold_load      = 1'b0;
        hold_load_val  = '0;
        hold_tick      = 1'b0;

        if (ack) begin
            state_d    = ST_IDLE;
            flash_d    = '0;
            overlay_d  = 1'b0;
            done_d     = 1'b0;
            phase_load = 1'b1;
            hold_load  = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (lose_rise) begin
                        state_d        = ST_FLASH;
                        flash_d        = FLASH_INIT;
                        overlay_d      = 1'b1;
                        phase_load     = 1'b1;
                        phase_load_val = PHASE_RELOAD;
                    end
                end
                ST_FLASH: begin
                    if (frame_tick) begin
                        if (phase_zero) begin
                            overlay_d      = ~overlay_q;
                            phase_load     = 1'b1;
                            phase_load_val = PHASE_RELOAD;
                            flash_d        = flash_q - FLASH_W'(1);
                            if (flash_q == FLASH_W'(1)) begin
                                state_d       = ST_HOLD;
                                overlay_d     = 1'b1;
                                hold_load     = 1'b1;
                                hold_load_val = HOLD_RELOAD;
                            end
                        end else begin
                            phase_tick = 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (frame_tick) begin
                        if (hold_zero) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            hold_tick = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    overlay_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            flash_q   <= '0;
            overlay_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            flash_q   <= flash_d;
            overlay_q <= overlay_d;
            done_q    <= done_d;
        end
    end

    assign overlay_en  = overlay_q;
    assign freeze_game = (state_q != ST_IDLE);

`ifdef GAME_OVER_IRQ_EN
    logic irq_mask_q;
    logic irq_q;

    // Interrupt mask register and registered interrupt request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            if (wr_en && (address == ADDR_IRQMASK)) begin
                irq_mask_q <= writedata[0];
            end
            irq_q <= done_q & irq_mask_q;
        end
    end

    assign irq = irq_q;
`endif

    // Combinational register read mux, zero-extended.
    always_comb begin
        readdata = '0;
        unique case (address)
            ADDR_STATUS:  readdata[2:0] = {done_q, state_q};
            ADDR_FLASH:   readdata[FLASH_W-1:0] = flash_q;
`ifdef GAME_OVER_IRQ_EN
            ADDR_IRQMASK: readdata[0] = irq_mask_q;
`endif
            default:      readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_game_over_sequencer.sv
// Self-checking bench for game_over_sequencer (FLASH_COUNT=3, TICKS_PER_PHASE=2,
// HOLD_TICKS=4). Covers the interrupt path when GAME_OVER_IRQ_EN is defined.
module tb_game_over_sequencer;

    localparam int FC  = 3;
    localparam int TPP = 2;
    localparam int HT  = 4;
    localparam int FT  = 2 * FC * TPP;
    localparam int TOT = FT + HT;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        lose_in;
    logic        frame_tick;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        overlay_en;
    logic        freeze_game;
`ifdef GAME_OVER_IRQ_EN
    logic        irq;
`endif

    game_over_sequencer #(
        .FLASH_COUNT     (FC),
        .TICKS_PER_PHASE (TPP),
        .HOLD_TICKS      (HT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .lose_in     (lose_in),
        .frame_tick  (frame_tick),
        .address     (address),
        .chipselect  (chipselect),
        .write_n     (write_n),
        .writedata   (writedata),
        .readdata    (readdata),
        .overlay_en  (overlay_en),
        .freeze_game (freeze_game)
`ifdef GAME_OVER_IRQ_EN
        ,
        .irq         (irq)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    // Behavioural model: a sequence is "busy" from the lose edge until ack,
    // and everything visible is a function of how many frame ticks it has seen.
    bit m_busy, m_primed, m_prev, m_mask, m_irq;
    int m_k;

    function automatic bit exp_done();
        return m_busy && (m_k >= TOT);
    endfunction

    function automatic int exp_state();
        if (!m_busy)   return 0;
        if (m_k < FT)  return 1;
        if (m_k < TOT) return 2;
        return 3;
    endfunction

    function automatic bit exp_overlay();
        return m_busy && ((m_k >= FT) || (((m_k / TPP) % 2) == 0));
    endfunction

    function automatic int exp_flash();
        return (m_k < FT) ? (2 * FC - m_k / TPP) : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!reset_n) begin
            m_busy = 0; m_k = 0; m_primed = 0; m_prev = 0; m_mask = 0; m_irq = 0;
        end else begin
            bit wr, ack, rise;
            wr   = chipselect && !write_n;
            ack  = wr && (address == 2'd3) && writedata[0];
            rise = m_primed && lose_in && !m_prev;
            m_irq = exp_done() && m_mask;
`ifdef GAME_OVER_IRQ_EN
            if (wr && (address == 2'd2)) m_mask = writedata[0];
`endif
            if (ack) begin
                m_busy = 0; m_k = 0;
            end else if (m_busy) begin
                if (frame_tick && (m_k < TOT)) m_k++;
            end else if (rise) begin
                m_busy = 1; m_k = 0;
            end
            m_prev   = lose_in;
            m_primed = 1;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("overlay_en", overlay_en, exp_overlay());
            check("freeze_game", freeze_game, m_busy);
            case (address)
                2'd0: check("addr0_status", readdata, {29'b0, exp_done(), 2'(exp_state())});
                2'd1: if (m_busy) check("addr1_flash", readdata, exp_flash());
`ifdef GAME_OVER_IRQ_EN
                2'd2: check("addr2_mask", readdata, {31'b0, m_mask});
`else
                2'd2: check("addr2_mask", readdata, 32'd0);
`endif
                default: check("addr3_read", readdata, 32'd0);
            endcase
`ifdef GAME_OVER_IRQ_EN
            check("irq", irq, m_irq);
`endif
        end
    end

    task automatic drive(input bit lose, input bit tick, input bit cs, input bit wn,
                         input logic [1:0] addr, input logic [31:0] wd);
        lose_in = lose; frame_tick = tick; chipselect = cs; write_n = wn;
        address = addr; writedata = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit lose, input logic [1:0] addr);
        drive(lose, 1'b0, 1'b0, 1'b1, addr, 32'd0);
    endtask

    initial begin
        int toggles;
        bit prev_ov, mono, lose_pat, lose_r;
        logic [31:0] last;

        reset_n = 0; lose_in = 0; frame_tick = 0; chipselect = 0; write_n = 1;
        address = 0; writedata = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_overlay", overlay_en, 0);
        check("rst_freeze", freeze_game, 0);
        check("rst_addr0", readdata, 0);
        reset_n = 1;
        check_en = 1;
        repeat (3) idle(0, 0);

        // Full sequence with lose_in wobbling during FLASH.
        drive(1, 0, 0, 1, 0, 0);
        check("enter_flash_addr0", readdata, 1);
        check("enter_flash_overlay", overlay_en, 1);
        check("enter_flash_freeze", freeze_game, 1);
        idle(1, 1);
        check("flash_init_addr1", readdata, 6);
        toggles = 0; prev_ov = overlay_en; mono = 1; last = readdata;
        for (int i = 1; i <= TOT; i++) begin
            lose_pat = (i % 3) != 1;
            drive(lose_pat, 1, 0, 1, (i < FT) ? 2'd1 : 2'd0, 0);
            if ((i <= FT) && (overlay_en !== prev_ov)) toggles++;
            prev_ov = overlay_en;
            if (i < FT) begin
                if (readdata > last) mono = 0;
                last = readdata;
            end
            if (i == FT - 1) check("flash_last_addr1", readdata, 1);
            if (i == FT)     check("hold_after_tick12", readdata, 2);
            if (i == TOT)    check("done_after_tick16", readdata, 7);
            idle(~lose_pat, (i < FT) ? 2'd1 : 2'd0);
        end
        check("overlay_toggles", toggles, 6);
        check("addr1_monotonic", mono, 1);
        repeat (3) idle(1, 0);
        check("done_sticky_addr0", readdata, 7);
        check("done_overlay", overlay_en, 1);

        // Ack and lose rising edge together in DONE.
        idle(0, 0);
        drive(1, 0, 1, 0, 3, 1);
        check("ack_edge_overlay", overlay_en, 0);
        check("ack_edge_freeze", freeze_game, 0);
        repeat (4) idle(1, 0);
        check("ack_edge_no_retrigger", readdata, 0);

        // Ack during HOLD.
        idle(0, 0);
        drive(1, 0, 0, 1, 0, 0);
        for (int i = 0; i < FT + 1; i++) drive(1, 1, 0, 1, 0, 0);
        check("hold_addr0", readdata, 2);
        drive(1, 0, 1, 0, 3, 1);
        check("ack_hold_overlay", overlay_en, 0);
        check("ack_hold_freeze", freeze_game, 0);
        idle(1, 0);
        check("ack_hold_addr0", readdata, 0);

        // Asynchronous reset mid-FLASH with lose_in held high.
        idle(0, 0);
        drive(1, 0, 0, 1, 0, 0);
        repeat (3) drive(1, 1, 0, 1, 0, 0);
        check_en = 0;
        #1 reset_n = 0;
        #1;
        check("async_rst_overlay", overlay_en, 0);
        check("async_rst_freeze", freeze_game, 0);
        check("async_rst_addr0", readdata, 0);
`ifdef GAME_OVER_IRQ_EN
        check("async_rst_irq", irq, 0);
`endif
        repeat (2) idle(1, 0);
        reset_n = 1;
        check_en = 1;
        repeat (4) idle(1, 0);
        check("post_rst_idle", readdata, 0);

`ifdef GAME_OVER_IRQ_EN
        drive(0, 0, 1, 0, 2, 1);
`endif

        // Randomized traffic against the model.
        lose_r = lose_in;
        for (int n = 0; n < 4000; n++) begin
            int r;
            bit tk;
            r  = $urandom_range(0, 99);
            tk = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 19) == 0) lose_r = ~lose_r;
            if (r < 2)      drive(lose_r, tk, 1, 0, 2'd3, $urandom);
            else if (r < 4) drive(lose_r, tk, 1, 0, 2'($urandom_range(0, 2)), $urandom);
            else if (r < 6) drive(lose_r, tk, 0, 0, 2'd3, 32'd1);
            else            drive(lose_r, tk, 0, 1, 2'($urandom_range(0, 3)), 32'd0);
        end

        check_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
